// File: rtl/dragonfang_pkg.sv
// Shared types and constants for the vector write-back sequencer.
package dragonfang_pkg;

    // Bytes carried by one VRF beat (one 64-bit vector register).
    localparam int VWB_BEAT_BYTES = 8;

    typedef enum logic [1:0] {
        VWB_SEW8  = 2'd0,
        VWB_SEW16 = 2'd1,
        VWB_SEW32 = 2'd2,
        VWB_SEW64 = 2'd3
    } vwb_sew_t;

    typedef enum logic [1:0] {
        VWB_LMUL1 = 2'd0,
        VWB_LMUL2 = 2'd1,
        VWB_LMUL4 = 2'd2,
        VWB_LMUL8 = 2'd3
    } vwb_lmul_t;

    typedef enum logic [2:0] {
        VWB_IDLE    = 3'd0,
        VWB_READ    = 3'd1,
        VWB_CAPTURE = 3'd2,
        VWB_MERGE   = 3'd3,
        VWB_WRITE   = 3'd4,
        VWB_DONE    = 3'd5
    } vwb_state_t;

    // Index of the final beat of a register group (nb - 1).
    function automatic logic [2:0] vwb_last_beat(input vwb_lmul_t lmul);
        logic [2:0] last;
        case (lmul)
            VWB_LMUL1: last = 3'd0;
            VWB_LMUL2: last = 3'd1;
            VWB_LMUL4: last = 3'd3;
            default:   last = 3'd7;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/vector_byte_class_gen.sv
// Per-byte classification of one write-back beat: active bytes take the
// execute result, undisturbed bytes keep the old register contents.
module vector_byte_class_gen
    import dragonfang_pkg::*;
(
    input  logic [2:0]  beat,
    input  logic [1:0]  sew,
    input  logic [6:0]  vl,
    input  logic        vm,
    input  logic        vta,
    input  logic        vma,
    input  logic [63:0] v0,
    output logic [7:0]  byte_active,
    output logic [7:0]  byte_undisturbed,
    output logic        any_undisturbed
);

    // beat * elements-per-register, as a shift: epr = 8 >> sew = 1 << (3 - sew).
    logic [1:0] epr_shift;
    logic [6:0] beat_base;

    assign epr_shift = 2'd3 - sew;
    assign beat_base = {4'd0, beat} << epr_shift;

    genvar gi;
    generate
        for (gi = 0; gi < VWB_BEAT_BYTES; gi++) begin : g_byte
            localparam logic [2:0] BYTE_IDX = 3'(gi);
            logic [6:0] elem;
            logic       tail;
            logic       active;
            logic       masked;

            // Element index never exceeds 63, so elem[5:0] addresses v0 directly.
            assign elem   = beat_base + {4'd0, BYTE_IDX >> sew};
            assign tail   = (elem >= vl);
            assign active = !tail && (vm || v0[elem[5:0]]);
            assign masked = !tail && !active;

            assign byte_active[gi]      = active;
            assign byte_undisturbed[gi] = (tail && !vta) || (masked && !vma);
        end
    endgenerate

    assign any_undisturbed = |byte_undisturbed;

endmodule

// File: rtl/vector_write_back_sequencer.sv
// Write-back sequencer: walks the register group of one vector instruction,
// fetches old data only when a beat has undisturbed bytes, merges it with
// the execute stream and issues one VRF write per register.
module vector_write_back_sequencer
    import dragonfang_pkg::*;
#(
    parameter int VLEN      = 64,
    parameter int NUM_VREGS = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [$clog2(NUM_VREGS)-1:0] req_vd,
    input  logic [1:0]                   req_lmul,
    input  logic [1:0]                   req_sew,
    input  logic [6:0]                   req_vl,
    input  logic                         req_vm,
    input  logic                         req_vta,
    input  logic                         req_vma,
    input  logic [VLEN-1:0]              req_v0,
    input  logic                         res_valid,
    output logic                         res_ready,
    input  logic [VLEN-1:0]              res_data,
    output logic                         vrf_rd_en,
    output logic [$clog2(NUM_VREGS)-1:0] vrf_rd_addr,
    input  logic [VLEN-1:0]              vrf_rd_data,
    output logic                         vrf_wr_en,
    output logic [$clog2(NUM_VREGS)-1:0] vrf_wr_addr,
    output logic [VLEN-1:0]              vrf_wr_data,
    output logic                         busy,
    output logic                         done
);

    localparam int AW = $clog2(NUM_VREGS);

    vwb_state_t        state_reg, state_next;

    // Job registers, captured on accept so later request changes are ignored.
    logic [AW-1:0]     vd_reg;
    vwb_lmul_t         lmul_reg;
    vwb_sew_t          sew_reg;
    logic [6:0]        vl_reg;
    logic              vm_reg;
    logic              vta_reg;
    logic              vma_reg;
    logic [VLEN-1:0]   v0_reg;

    logic [2:0]        beat_reg;
    logic [VLEN-1:0]   old_reg;
    logic [AW-1:0]     wr_addr_reg;
    logic [VLEN-1:0]   wr_data_reg;

    logic [AW-1:0]     beat_addr;
    logic              last_beat;

    // Classifier inputs are muxed: request fields for beat 0 while idle,
    // the upcoming beat while writing, otherwise the current beat.
    logic [2:0]        cls_beat;
    logic [1:0]        cls_sew;
    logic [6:0]        cls_vl;
    logic              cls_vm;
    logic              cls_vta;
    logic              cls_vma;
    logic [VLEN-1:0]   cls_v0;
    logic [7:0]        byte_active;
    logic [7:0]        byte_undisturbed;
    logic              any_undisturbed;
    logic [VLEN-1:0]   merged_data;

    // Register index wraps naturally modulo the register file size.
    assign beat_addr = vd_reg + AW'(beat_reg);
    assign last_beat = (beat_reg == vwb_last_beat(lmul_reg));

    // Select which beat the classifier evaluates this cycle.
    always_comb begin
        cls_beat = beat_reg;
        cls_sew  = sew_reg;
        cls_vl   = vl_reg;
        cls_vm   = vm_reg;
        cls_vta  = vta_reg;
        cls_vma  = vma_reg;
        cls_v0   = v0_reg;
        if (state_reg == VWB_IDLE) begin
            cls_beat = 3'd0;
            cls_sew  = req_sew;
            cls_vl   = req_vl;
            cls_vm   = req_vm;
            cls_vta  = req_vta;
            cls_vma  = req_vma;
            cls_v0   = req_v0;
        end else if (state_reg == VWB_WRITE) begin
            cls_beat = beat_reg + 3'd1;
        end
    end

    vector_byte_class_gen u_class (
        .beat             (cls_beat),
        .sew              (cls_sew),
        .vl               (cls_vl),
        .vm               (cls_vm),
        .vta              (cls_vta),
        .vma              (cls_vma),
        .v0               (cls_v0),
        .byte_active      (byte_active),
        .byte_undisturbed (byte_undisturbed),
        .any_undisturbed  (any_undisturbed)
    );

    genvar gi;
    generate
        for (gi = 0; gi < VWB_BEAT_BYTES; gi++) begin : g_merge
            assign merged_data[gi*8 +: 8] = byte_active[gi]      ? res_data[gi*8 +: 8] :
                                            byte_undisturbed[gi] ? old_reg[gi*8 +: 8]  :
                                                                   8'hFF;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= VWB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake/strobe decode.
    always_comb begin
        state_next  = state_reg;
        req_ready   = 1'b0;
        res_ready   = 1'b0;
        vrf_rd_en   = 1'b0;
        vrf_rd_addr = '0;
        vrf_wr_en   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state_reg)
            VWB_IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_vl == 7'd0) begin
                        state_next = VWB_DONE;
                    end else if (any_undisturbed) begin
                        state_next = VWB_READ;
                    end else begin
                        state_next = VWB_MERGE;
                    end
                end
            end
            VWB_READ: begin
                vrf_rd_en   = 1'b1;
                vrf_rd_addr = beat_addr;
                state_next  = VWB_CAPTURE;
            end
            VWB_CAPTURE: begin
                state_next = VWB_MERGE;
            end
            VWB_MERGE: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    state_next = VWB_WRITE;
                end
            end
            VWB_WRITE: begin
                vrf_wr_en = 1'b1;
                if (last_beat) begin
                    state_next = VWB_DONE;
                end else if (any_undisturbed) begin
                    state_next = VWB_READ;
                end else begin
                    state_next = VWB_MERGE;
                end
            end
            VWB_DONE: begin
                done       = 1'b1;
                state_next = VWB_IDLE;
            end
            default: begin
                state_next = VWB_IDLE;
            end
        endcase
    end

    // Job capture, beat counter, old-data capture and registered write beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vd_reg      <= '0;
            lmul_reg    <= VWB_LMUL1;
            sew_reg     <= VWB_SEW8;
            vl_reg      <= '0;
            vm_reg      <= 1'b0;
            vta_reg     <= 1'b0;
            vma_reg     <= 1'b0;
            v0_reg      <= '0;
            beat_reg    <= '0;
            old_reg     <= '0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            case (state_reg)
                VWB_IDLE: begin
                    if (req_valid) begin
                        vd_reg   <= req_vd;
                        lmul_reg <= vwb_lmul_t'(req_lmul);
                        sew_reg  <= vwb_sew_t'(req_sew);
                        vl_reg   <= req_vl;
                        vm_reg   <= req_vm;
                        vta_reg  <= req_vta;
                        vma_reg  <= req_vma;
                        v0_reg   <= req_v0;
                        beat_reg <= 3'd0;
                    end
                end
                VWB_CAPTURE: begin
                    old_reg <= vrf_rd_data;
                end
                VWB_MERGE: begin
                    if (res_valid) begin
                        wr_addr_reg <= beat_addr;
                        wr_data_reg <= merged_data;
                    end
                end
                VWB_WRITE: begin
                    // Hold on the last beat so the counter never wraps within a job.
                    if (!last_beat) begin
                        beat_reg <= beat_reg + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign vrf_wr_addr = wr_addr_reg;
    assign vrf_wr_data = wr_data_reg;

endmodule

// File: tb/tb_vector_write_back_sequencer.sv
// Scoreboard bench for the vector write-back sequencer.
module tb_vector_write_back_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_vd;
    logic [1:0]  req_lmul;
    logic [1:0]  req_sew;
    logic [6:0]  req_vl;
    logic        req_vm;
    logic        req_vta;
    logic        req_vma;
    logic [63:0] req_v0;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        vrf_rd_en;
    logic [4:0]  vrf_rd_addr;
    logic [63:0] vrf_rd_data;
    logic        vrf_wr_en;
    logic [4:0]  vrf_wr_addr;
    logic [63:0] vrf_wr_data;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int wr_seen = 0;
    int rd_seen = 0;
    int beats_seen = 0;
    int done_seen = 0;

    logic [63:0] vrf_mem [32];
    logic [4:0]  exp_wr_addr_q [$];
    logic [63:0] exp_wr_data_q [$];
    logic [4:0]  exp_rd_q [$];
    logic [4:0]  mon_addr;
    logic [63:0] mon_data;

    always #5 clk = ~clk;

    vector_write_back_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_vd      (req_vd),
        .req_lmul    (req_lmul),
        .req_sew     (req_sew),
        .req_vl      (req_vl),
        .req_vm      (req_vm),
        .req_vta     (req_vta),
        .req_vma     (req_vma),
        .req_v0      (req_v0),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .vrf_rd_en   (vrf_rd_en),
        .vrf_rd_addr (vrf_rd_addr),
        .vrf_rd_data (vrf_rd_data),
        .vrf_wr_en   (vrf_wr_en),
        .vrf_wr_addr (vrf_wr_addr),
        .vrf_wr_data (vrf_wr_data),
        .busy        (busy),
        .done        (done)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // VRF read port: one-cycle latency.
    always @(posedge clk) begin
        if (vrf_rd_en) vrf_rd_data <= vrf_mem[vrf_rd_addr];
    end

    // Result beats consumed on the handshake edge.
    always @(posedge clk) begin
        if (reset_n && res_valid && res_ready) beats_seen++;
    end

    // Output monitor: writes and reads popped against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (vrf_wr_en) begin
                wr_seen++;
                $display("wr addr=%0d data=%h", vrf_wr_addr, vrf_wr_data);
                if (exp_wr_addr_q.size() == 0) begin
                    check_val("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_addr = exp_wr_addr_q.pop_front();
                    mon_data = exp_wr_data_q.pop_front();
                    check_val("wr_addr", {59'd0, vrf_wr_addr}, {59'd0, mon_addr});
                    check_val("wr_data", vrf_wr_data, mon_data);
                end
            end
            if (vrf_rd_en) begin
                rd_seen++;
                $display("rd addr=%0d", vrf_rd_addr);
                if (exp_rd_q.size() == 0) begin
                    check_val("rd_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_addr = exp_rd_q.pop_front();
                    check_val("rd_addr", {59'd0, vrf_rd_addr}, {59'd0, mon_addr});
                end
            end
            if (done) done_seen++;
        end
    end

    // Reference merge of one beat, element by element.
    function automatic void model_beat(input int b, input int sew, input int vl, input bit vm,
                                       input bit vta, input bit vma, input logic [63:0] v0,
                                       input logic [63:0] res, input logic [63:0] old,
                                       output logic [63:0] data, output bit need_rd);
        int epr = 8 >> sew;
        int bpe = 1 << sew;
        data = '0;
        need_rd = 1'b0;
        for (int j = 0; j < epr; j++) begin
            int e = b * epr + j;
            bit t = (e >= vl);
            bit act = !t && (vm || v0[e]);
            bit und = (t && !vta) || (!t && !act && !vma);
            for (int k = j * bpe; k < (j + 1) * bpe; k++) begin
                if (act)      data[k*8 +: 8] = res[k*8 +: 8];
                else if (und) data[k*8 +: 8] = old[k*8 +: 8];
                else          data[k*8 +: 8] = 8'hFF;
            end
            if (und) need_rd = 1'b1;
        end
    endfunction

    task automatic run_job(input string name, input logic [4:0] vd, input int lmul, input int sew,
                           input int vl, input bit vm, input bit vta, input bit vma,
                           input logic [63:0] v0, input logic [63:0] res0,
                           input bit use_lit, input logic [63:0] lit0, input bit stall);
        int nb = 1 << lmul;
        int rd_exp = 0;
        int wr0, rd0, bt0, dn0, cnt;
        logic [63:0] beats [8];
        logic [63:0] d;
        logic [4:0]  a;
        bit nr;
        for (int b = 0; b < nb; b++) begin
            beats[b] = (b == 0) ? res0 : {$urandom, $urandom};
            a = vd + 5'(b);
            model_beat(b, sew, vl, vm, vta, vma, v0, beats[b], vrf_mem[a], d, nr);
            if (b == 0 && use_lit) d = lit0;
            if (vl != 0) begin
                exp_wr_addr_q.push_back(a);
                exp_wr_data_q.push_back(d);
                if (nr) begin
                    exp_rd_q.push_back(a);
                    rd_exp++;
                end
            end
        end
        wr0 = wr_seen; rd0 = rd_seen; bt0 = beats_seen; dn0 = done_seen;
        $display("job %s vd=%0d lmul=%0d sew=%0d vl=%0d vm=%0d vta=%0d vma=%0d", name, vd, lmul, sew, vl, vm, vta, vma);
        req_vd = vd; req_lmul = 2'(lmul); req_sew = 2'(sew); req_vl = 7'(vl);
        req_vm = vm; req_vta = vta; req_vma = vma; req_v0 = v0; req_valid = 1'b1;
        cnt = 0;
        while (!req_ready && cnt < 50) begin @(negedge clk); cnt++; end
        check_val({name, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_vd = 5'($urandom); req_lmul = 2'($urandom); req_sew = 2'($urandom);
        req_vl = 7'($urandom); req_vm = 1'($urandom); req_vta = 1'($urandom);
        req_vma = 1'($urandom); req_v0 = {$urandom, $urandom};
        if (vl != 0) begin
            for (int b = 0; b < nb; b++) begin
                if (stall) begin
                    res_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                res_valid = 1'b1;
                res_data = beats[b];
                cnt = 0;
                while (!res_ready && cnt < 100) begin @(negedge clk); cnt++; end
                if (!res_ready) begin
                    check_val({name, "_beat_timeout"}, 64'd0, 64'd1);
                    break;
                end
                @(negedge clk);
            end
            res_valid = 1'b0;
        end else begin
            res_valid = 1'b1;
            res_data = {$urandom, $urandom};
        end
        cnt = 0;
        #1;
        while (done_seen == dn0 && cnt < 100) begin @(negedge clk); #1; cnt++; end
        if (vl == 0) check_val({name, "_done_latency"}, 64'(cnt <= 2), 64'd1);
        repeat (2) @(negedge clk);
        res_valid = 1'b0;
        check_val({name, "_done"}, 64'(done_seen - dn0), 64'd1);
        check_val({name, "_beats"}, 64'(beats_seen - bt0), 64'((vl != 0) ? nb : 0));
        check_val({name, "_writes"}, 64'(wr_seen - wr0), 64'((vl != 0) ? nb : 0));
        check_val({name, "_reads"}, 64'(rd_seen - rd0), 64'(rd_exp));
        check_val({name, "_q_empty"}, 64'(exp_wr_addr_q.size() + exp_rd_q.size()), 64'd0);
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0;
        req_valid = 1'b0; req_vd = '0; req_lmul = '0; req_sew = '0; req_vl = '0;
        req_vm = 1'b0; req_vta = 1'b0; req_vma = 1'b0; req_v0 = '0;
        res_valid = 1'b0; res_data = '0;
        for (int i = 0; i < 32; i++) vrf_mem[i] = {$urandom, $urandom};
        vrf_mem[4] = 64'hAAAA_AAAA_0000_0000;
        repeat (3) @(negedge clk);
        check_val("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check_val("rst_outputs", {57'd0, res_ready, vrf_rd_en, vrf_wr_en, busy, done, 2'b00}, 64'd0);
        check_val("rst_wr_addr", {59'd0, vrf_wr_addr}, 64'd0);
        check_val("rst_wr_data", vrf_wr_data, 64'd0);
        check_val("rst_rd_addr", {59'd0, vrf_rd_addr}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_job("sew8_full", 5'd3, 0, 0, 8, 1'b1, 1'b0, 1'b0, 64'd0,
                64'h0807060504030201, 1'b1, 64'h0807060504030201, 1'b0);
        run_job("sew32_tail", 5'd4, 0, 2, 1, 1'b1, 1'b0, 1'b0, 64'd0,
                64'h1111_1111_2222_2222, 1'b1, 64'hAAAA_AAAA_2222_2222, 1'b0);
        run_job("sew16_mask", 5'd7, 0, 1, 4, 1'b0, 1'b1, 1'b1, 64'b0101,
                64'h4444_3333_2222_1111, 1'b1, 64'hFFFF_3333_FFFF_1111, 1'b0);
        run_job("lmul4_wrap", 5'd30, 2, 3, 2, 1'b1, 1'b0, 1'b1, 64'd0,
                {$urandom, $urandom}, 1'b0, 64'd0, 1'b1);
        run_job("vl0", 5'd9, 1, 0, 0, 1'b1, 1'b0, 1'b0, 64'd0,
                64'd0, 1'b0, 64'd0, 1'b0);
        run_job("lmul8_full", 5'd12, 3, 0, 64, 1'b0, 1'b0, 1'b0, {$urandom, $urandom},
                {$urandom, $urandom}, 1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_job($sformatf("rand%0d", i), 5'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 64)), 1'($urandom),
                    1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    1'b0, 64'd0, 1'b1);
        end

        // Reset during the write of beat 1 of a two-register job.
        $display("job rst_mid lmul=1 sew=0 vl=16");
        model_beat(0, 0, 16, 1'b1, 1'b0, 1'b0, 64'd0, 64'h0102030405060708, vrf_mem[20], mon_data, cnt[0]);
        exp_wr_addr_q.push_back(5'd20);
        exp_wr_data_q.push_back(mon_data);
        req_vd = 5'd20; req_lmul = 2'd1; req_sew = 2'd0; req_vl = 7'd16;
        req_vm = 1'b1; req_vta = 1'b0; req_vma = 1'b0; req_v0 = '0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        res_valid = 1'b1;
        res_data = 64'h0102030405060708;
        cnt = 0;
        while (!res_ready && cnt < 50) begin @(negedge clk); cnt++; end
        @(negedge clk);
        res_data = 64'hDEAD_BEEF_DEAD_BEEF;
        cnt = 0;
        while (!res_ready && cnt < 50) begin @(negedge clk); cnt++; end
        @(posedge clk);
        #1;
        check_val("rstmid_pre_wr_en", {63'd0, vrf_wr_en}, 64'd1);
        reset_n = 1'b0;
        res_valid = 1'b0;
        #1;
        check_val("rstmid_wr_en", {63'd0, vrf_wr_en}, 64'd0);
        check_val("rstmid_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("rstmid_req_ready", {63'd0, req_ready}, 64'd1);
        check_val("rstmid_idle", {62'd0, busy, vrf_wr_en}, 64'd0);
        check_val("rstmid_q_empty", 64'(exp_wr_addr_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
